acc8_stream: RTL

ACC8_STREAM -- requirements
Module: acc8_stream

---
 rtl/acc8_stream.sv | 137 +++++++++++++
 1 files changed

// File: rtl/acc8_stream.sv
// acc8_stream: sums N_SAMPLES unsigned 8-bit beats per burst and emits one 8-bit result plus a carry-out flag.
// Latency: the result is valid 1 cycle after the final accepted beat. There is one idle cycle between bursts.
// Backpressure: in_ready drops while a result is held. out_sum and out_ovf stay stable until out_ready is seen.
//
// Ports:
//   clk, rst_n             single rising-edge clock; asynchronous active-low reset
//   in_valid/in_ready      operand handshake; in_data is the unsigned operand
//   out_valid/out_ready    result handshake; out_sum is the burst sum mod 256
//   out_ovf                set if any addition in the burst carried out of bit 7
//   busy                   a burst is partly accepted and no result is pending
//
// rca8 is the shared 8-bit ripple-carry adder. It has no carry-out port.

module rca8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum
);
  logic [7:0] c;

  always_comb begin
    c      = '0;
    sum    = '0;
    c[0]   = cin;
    for (int i = 0; i < 7; i++) begin
      c[i+1] = (a[i] & b[i]) | ((a[i] ^ b[i]) & c[i]);
    end
    for (int i = 0; i < 8; i++) begin
      sum[i] = a[i] ^ b[i] ^ c[i];
    end
  end
endmodule

module acc8_stream #(
  parameter int unsigned N_SAMPLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_sum,
  output logic       out_ovf,
  output logic       busy
);
  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  localparam logic [7:0] CNT_LAST = 8'(N_SAMPLES - 1);

  state_t     state_q, state_d;
  logic [7:0] acc_q, acc_d;
  logic [7:0] cnt_q, cnt_d;
  logic       ovf_q, ovf_d;
  logic [7:0] out_sum_q, out_sum_d;
  logic       out_ovf_q, out_ovf_d;

  logic [7:0] add_sum;
  logic       add_carry;
  logic       accept;

  rca8 u_add (
    .a   (acc_q),
    .b   (in_data),
    .cin (1'b0),
    .sum (add_sum)
  );

  // Carry out of bit 7 is recovered from the operand and sum MSBs.
  // A carry occurs if both operand MSBs are set.
  // It also occurs if exactly one is set and the sum MSB is clear, because a carry into bit 7 flipped it.
  assign add_carry = (acc_q[7] & in_data[7]) | ((acc_q[7] | in_data[7]) & ~add_sum[7]);

  // Handshake outputs are decoded from state only, so there is no path from in_valid or out_ready.
  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == HOLD);
  assign accept    = in_valid & in_ready;
  assign busy      = (state_q == ACCUM) && (cnt_q != 8'd0);
  assign out_sum   = out_sum_q;
  assign out_ovf   = out_ovf_q;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    out_sum_d = out_sum_q;
    out_ovf_d = out_ovf_q;

    case (state_q)
      ACCUM: begin
        if (accept) begin
          acc_d = add_sum;
          ovf_d = ovf_q | add_carry;
          if (cnt_q == CNT_LAST) begin
            // cnt is held at N-1 through HOLD and cleared on the result handshake.
            // This keeps it from ever reaching N_SAMPLES.
            state_d   = HOLD;
            out_sum_d = add_sum;
            out_ovf_d = ovf_q | add_carry;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = ACCUM;
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ACCUM;
      acc_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      out_sum_q <= '0;
      out_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      out_sum_q <= out_sum_d;
      out_ovf_q <= out_ovf_d;
    end
  end
endmodule
